psdsumsq: RTL and testbench

Sequential sum-of-squares stage that sits directly upstream of the square-root calculator: it takes a signed 2-D sample (x, y), computes x² + y² with a shift-add multiplier, and hands the 32-bit unsigned result to the sqrt block. It drives the sqrt block's `run` and `xin` inputs and observes its `busy`. Together the two blocks form the vector-magnitude path |(x, y)|.

---
 rtl/psdsumsq_pkg.sv | 14 +
 rtl/psdsumsq_if.sv | 15 +
 rtl/psdsumsq_serial_mul.sv | 62 ++++++
 rtl/psdsumsq.sv | 137 +++++++++++++
 tb/tb_psdsumsq.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psdsumsq_pkg.sv
// Shared definitions for the sum-of-squares stage feeding the sqrt block.
package psdsumsq_pkg;

  localparam int unsigned NBITS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULX  = 3'd1,
    ST_MULY  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_RUN   = 3'd4
  } psd_state_t;

endpackage

// File: rtl/psdsumsq_if.sv
// Operand/result bundle between the requester, psdsumsq and the sqrt block.
interface psdsumsq_if #(parameter int NBITS = 16);

  logic               start;
  logic [NBITS-1:0]   x;
  logic [NBITS-1:0]   y;
  logic               busy;
  logic [2*NBITS-1:0] sumsq;
  logic               run_sqrt;
  logic               sqrt_busy;

  modport master (output start, x, y, sqrt_busy, input busy, sumsq, run_sqrt);
  modport slave  (input start, x, y, sqrt_busy, output busy, sumsq, run_sqrt);

endinterface

// File: rtl/psdsumsq_serial_mul.sv
// One-bit-per-cycle shift-add multiplier step unit; the accumulator survives
// an operand reload so two squares can be summed back to back.
module psdsumsq_serial_mul #(
  parameter int NBITS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               clear_acc,
  input  logic [NBITS-1:0]   load_val,
  output logic [2*NBITS-1:0] acc_next,
  output logic               last
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [2*NBITS-1:0] mcand_r;
  logic [2*NBITS-1:0] acc_r;
  logic [NBITS-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;

  // accumulator value after this cycle's conditional add
  always_comb begin
    if (mplier_r[0]) begin
      acc_next = acc_r + mcand_r;
    end else begin
      acc_next = acc_r;
    end
  end

  assign last = (cnt_r == CNT_LAST);

  // operand shift registers, step counter and accumulator
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      acc_r    <= '0;
    end else begin
      if (clear_acc) begin
        acc_r <= '0;
      end else if (step) begin
        acc_r <= acc_next;
      end
      // a reload on the final step still lets that step's add land in acc_r
      if (load) begin
        mcand_r  <= {{NBITS{1'b0}}, load_val};
        mplier_r <= load_val;
        cnt_r    <= '0;
      end else if (step) begin
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        cnt_r    <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/psdsumsq.sv
// Sequential x^2 + y^2 stage: squares |x| then |y| on one serial multiplier
// and hands the unsigned sum to the sqrt block with a one-cycle run pulse.
module psdsumsq
  import psdsumsq_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input logic       clock,
  input logic       reset,
  psdsumsq_if.slave bus
);

  localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};

  psd_state_t         state_r;
  logic [NBITS-1:0]   ay_r;
  logic [2*NBITS-1:0] sumsq_r;
  logic               busy_r;
  logic               run_sqrt_r;

  logic [NBITS-1:0]   abs_x_s;
  logic [NBITS-1:0]   abs_y_s;
  logic               mul_load_s;
  logic               mul_step_s;
  logic               mul_clear_s;
  logic [NBITS-1:0]   mul_val_s;
  logic [2*NBITS-1:0] acc_next_s;
  logic               mul_last_s;

  // magnitudes; the most negative input maps onto 2^(NBITS-1) without overflow
  always_comb begin
    if (bus.x[NBITS-1]) begin
      abs_x_s = ~bus.x + ONE;
    end else begin
      abs_x_s = bus.x;
    end
    if (bus.y[NBITS-1]) begin
      abs_y_s = ~bus.y + ONE;
    end else begin
      abs_y_s = bus.y;
    end
  end

  // multiplier sequencing from the registered state
  always_comb begin
    mul_load_s  = 1'b0;
    mul_step_s  = 1'b0;
    mul_clear_s = 1'b0;
    mul_val_s   = abs_x_s;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          mul_load_s  = 1'b1;
          mul_clear_s = 1'b1;
        end else begin
          mul_load_s  = 1'b0;
          mul_clear_s = 1'b0;
        end
      end
      ST_MULX: begin
        mul_step_s = 1'b1;
        if (mul_last_s) begin
          mul_load_s = 1'b1;
          mul_val_s  = ay_r;
        end else begin
          mul_load_s = 1'b0;
        end
      end
      ST_MULY: mul_step_s = 1'b1;
      default: mul_step_s = 1'b0;
    endcase
  end

  psdsumsq_serial_mul #(.NBITS(NBITS)) u_mul (
    .clock     (clock),
    .reset     (reset),
    .load      (mul_load_s),
    .step      (mul_step_s),
    .clear_acc (mul_clear_s),
    .load_val  (mul_val_s),
    .acc_next  (acc_next_s),
    .last      (mul_last_s)
  );

  // control FSM with registered busy/run_sqrt and the held result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ay_r       <= '0;
      sumsq_r    <= '0;
      busy_r     <= 1'b0;
      run_sqrt_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            ay_r    <= abs_y_s;
            busy_r  <= 1'b1;
            state_r <= ST_MULX;
          end
        end
        ST_MULX: begin
          if (mul_last_s) begin
            state_r <= ST_MULY;
          end
        end
        ST_MULY: begin
          if (mul_last_s) begin
            sumsq_r <= acc_next_s;
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.sqrt_busy) begin
            run_sqrt_r <= 1'b1;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          run_sqrt_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          run_sqrt_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.run_sqrt = run_sqrt_r;
  assign bus.sumsq    = sumsq_r;

endmodule

// File: tb/tb_psdsumsq.sv
// Scoreboard bench for psdsumsq, with a small behavioural sqrt partner.
module tb_psdsumsq;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  psdsumsq_if #(.NBITS(16)) bus ();

  psdsumsq #(.NBITS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  logic tb_sbusy = 1'b0;
  logic use_model = 1'b0;
  logic m_busy;
  logic [3:0] m_cnt;
  logic [31:0] m_in;
  int m_out;
  logic m_done;

  assign bus.sqrt_busy = use_model ? m_busy : tb_sbusy;

  function automatic int isqrt(input logic [31:0] v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(v)) r++;
    return int'(r);
  endfunction

  // behavioural sqrt: busy for a few cycles after run, then presents the root
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 4'd0;
      m_in   <= 32'd0;
      m_out  <= 0;
      m_done <= 1'b0;
    end else if (use_model) begin
      if (bus.run_sqrt && !m_busy) begin
        m_busy <= 1'b1;
        m_cnt  <= 4'd5;
        m_in   <= bus.sumsq;
        m_done <= 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 4'd1) begin
          m_busy <= 1'b0;
          m_out  <= isqrt(m_in);
          m_done <= 1'b1;
        end
        m_cnt <= m_cnt - 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic launch(input int xv, input int yv);
    longint e;
    e = longint'(xv) * xv + longint'(yv) * yv;
    exp_q.push_back(e[31:0]);
    bus.x = xv[15:0];
    bus.y = yv[15:0];
    bus.start = 1'b1;
    cyc = 0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_run(output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    lat = -1;
    while (bus.run_sqrt !== 1'b1 && cyc < 300) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
    end
    if (bus.run_sqrt === 1'b1) lat = cyc;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.run_sqrt !== 1'b0 || bus.sumsq !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b run=%b sumsq=%h expected 0/0/0", bus.busy, bus.run_sqrt, bus.sumsq);
    end
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
  endtask

  task automatic test_basic();
    bit ok = 1'b1;
    logic [31:0] e;
    launch(3, 4);
    while (cyc < 33) begin
      if (bus.busy !== 1'b1 || bus.run_sqrt !== 1'b0) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_busy_window: busy/run wrong in cycles 1-32"); end
    checks++;
    if (bus.sumsq !== 32'd25 || bus.run_sqrt !== 1'b0) begin
      failures++;
      $display("FAIL basic_sumsq_c33: sumsq=%0d run=%b expected 25/0", bus.sumsq, bus.run_sqrt);
    end
    tick();
    checks++;
    if (bus.run_sqrt !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_run_c34: run=%b busy=%b expected 1/1", bus.run_sqrt, bus.busy);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (bus.sumsq !== e) begin failures++; $display("FAIL basic_scoreboard: got %h expected %h", bus.sumsq, e); end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.run_sqrt !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_c35: busy=%b run=%b expected 0/0", bus.busy, bus.run_sqrt);
    end
  endtask

  task automatic test_extremes();
    int xs[2] = '{-32768, 32767};
    int ys[2] = '{-32768, -1};
    logic [31:0] want[2] = '{32'h8000_0000, 32'h3FFF_0002};
    int lat;
    bit bok;
    logic [31:0] e;
    for (int i = 0; i < 2; i++) begin
      launch(xs[i], ys[i]);
      wait_run(lat, bok);
      checks++;
      if (lat != 34 || !bok) begin failures++; $display("FAIL extreme_latency_%0d: lat=%0d busy_ok=%0d expected 34/1", i, lat, bok); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (bus.sumsq !== e || bus.sumsq !== want[i]) begin
        failures++;
        $display("FAIL extreme_sumsq_%0d: got %h expected %h", i, bus.sumsq, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit busy_ok = 1'b1;
    bit stable = 1'b1;
    int lat = -1;
    int last_hi = 44;
    logic [31:0] e;
    launch(-1234, 567);
    e = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
    while (bus.run_sqrt !== 1'b1 && cyc < 300) begin
      if (cyc == 20) tb_sbusy = 1'b1;
      if (cyc == last_hi + 1) tb_sbusy = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc >= 33 && bus.sumsq !== e) stable = 1'b0;
      tick();
    end
    if (bus.run_sqrt === 1'b1) lat = cyc;
    tb_sbusy = 1'b0;
    checks++;
    if (lat != 34 + (last_hi - 33 + 1)) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", lat, 34 + (last_hi - 33 + 1)); end
    checks++;
    if (!busy_ok || !stable) begin failures++; $display("FAIL bp_hold: busy_ok=%0d sumsq_stable=%0d expected 1/1", busy_ok, stable); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (bus.sumsq !== e) begin failures++; $display("FAIL bp_scoreboard: got %h expected %h", bus.sumsq, e); end
    tick();
    checks++;
    if (bus.sumsq !== e || bus.busy !== 1'b0) begin failures++; $display("FAIL bp_after_run: sumsq=%h busy=%b expected %h/0", bus.sumsq, bus.busy, e); end
  endtask

  task automatic test_ignored_start();
    int lat;
    bit bok;
    logic [31:0] e;
    launch(5, 7);
    while (bus.run_sqrt !== 1'b1 && cyc < 300) begin
      if (cyc == 10) begin bus.start = 1'b1; bus.x = 16'd100; end
      else bus.start = 1'b0;
      tick();
    end
    checks++;
    if (cyc != 34) begin failures++; $display("FAIL ign_latency: got %0d expected 34", cyc); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (bus.sumsq !== e) begin failures++; $display("FAIL ign_scoreboard: got %0d expected %0d", bus.sumsq, e); end
    bus.start = 1'b1; bus.x = 16'd100; bus.y = 16'd100;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL ign_run_cycle_start: busy=%b expected 0", bus.busy); end
    launch(100, 0);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL ign_accept_c35: busy=%b expected 1", bus.busy); end
    wait_run(lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (lat != 34 || bus.sumsq !== e) begin failures++; $display("FAIL ign_second_op: lat=%0d sumsq=%0d expected 34/%0d", lat, bus.sumsq, e); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    int lat;
    bit bok;
    logic [31:0] e;
    launch(1000, -2000);
    while (cyc < 20) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.run_sqrt !== 1'b0 || bus.sumsq !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_clear: busy=%b run=%b sumsq=%h expected 0/0/0", bus.busy, bus.run_sqrt, bus.sumsq);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    #2 reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.run_sqrt !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin failures++; $display("FAIL rst_mid_no_pulse: run/busy seen after abort"); end
    launch(0, 0);
    wait_run(lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (lat != 34 || !bok || bus.sumsq !== e) begin
      failures++;
      $display("FAIL rst_mid_next_op: lat=%0d busy_ok=%0d sumsq=%h expected 34/1/%h", lat, bok, bus.sumsq, e);
    end
    tick();
  endtask

  task automatic test_integration();
    int lat;
    bit bok;
    int n = 0;
    logic [31:0] e;
    use_model = 1'b1;
    launch(6, 8);
    wait_run(lat, bok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (bus.sumsq !== e) begin failures++; $display("FAIL integ_sumsq: got %0d expected %0d", bus.sumsq, e); end
    tick();
    while (m_done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (m_done !== 1'b1 || m_out != 10) begin failures++; $display("FAIL integ_sqrt: done=%b root=%0d expected 1/10", m_done, m_out); end
    use_model = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x = 16'd0;
    bus.y = 16'd0;
    test_reset();
    tick();
    test_basic();
    test_extremes();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_integration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
